snn_core_param: RTL and testbench

//  Parametrised two-layer fully-connected inference core.

---
 rtl/snn_core_param.sv | 209 ++++++++++++++++++++
 tb/tb_snn_core_param.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_core_param.sv
`timescale 1ns/1ps
// snn_core_param: two-layer fully-connected classifier (binary image -> hidden -> output, argmax).
// Build option SNN_TIE_LAST_EN: argmax ties resolve to the highest output index instead of the lowest.
module snn_core_param #(
  parameter int N_IN  = 784,
  parameter int N_HID = 32,
  parameter int N_OUT = 10,
  parameter int DW    = 8,
  parameter int ACC_W = 26
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  output logic                                    busy,
  output logic                                    done,
  output logic [$clog2(N_OUT)-1:0]                digit,
  output logic signed [DW-1:0]                    max_val,
  output logic [$clog2(N_IN)-1:0]                 addr_in,
  input  logic                                    q_in,
  output logic [$clog2(N_HID)+$clog2(N_IN)-1:0]   addr_wh,
  input  logic signed [DW-1:0]                    q_wh,
  output logic [$clog2(N_OUT)+$clog2(N_HID)-1:0]  addr_wo,
  input  logic signed [DW-1:0]                    q_wo,
  output logic [10:0]                             act_addr,
  input  logic signed [DW-1:0]                    act_q
);

  localparam int IN_W  = $clog2(N_IN);
  localparam int HID_W = $clog2(N_HID);
  localparam int OUT_W = $clog2(N_OUT);

  localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(N_IN - 1);
  localparam logic [HID_W-1:0] HID_LAST = HID_W'(N_HID - 1);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(N_OUT - 1);

  localparam logic signed [DW-1:0]    PIX_ONE = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] S_MAX   = ACC_W'(1023);
  localparam logic signed [ACC_W-1:0] S_MIN   = ACC_W'(-1024);

  typedef enum logic [3:0] {
    IDLE, H_MAC, H_DRN, H_ACT, H_WB, O_MAC, O_DRN, O_ACT, O_WB, DONE
  } state_t;

  state_t                   state;
  logic [IN_W-1:0]          in_idx;
  logic [HID_W-1:0]         hid_idx;
  logic [OUT_W-1:0]         out_idx;
  logic signed [ACC_W-1:0]  acc;
  logic                     mac_vld;
  logic signed [DW-1:0]     hid [N_HID];
  logic signed [DW-1:0]     hid_op;
  logic signed [DW-1:0]     best_val;
  logic [OUT_W-1:0]         best_idx;

  logic signed [DW-1:0]     a_op;
  logic signed [DW-1:0]     b_op;
  logic signed [2*DW-1:0]   prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [10:0]       clamped;
  logic [10:0]              act_next;
  logic                     take;

  assign addr_in = in_idx;
  assign addr_wh = {hid_idx, in_idx};
  assign addr_wo = {out_idx, hid_idx};

  // Memory data arrives one cycle after its address, so the operand source follows the
  // state that consumes it; the first MAC cycle of each unit is masked by mac_vld.
  always_comb begin
    a_op = q_in ? PIX_ONE : '0;
    b_op = q_wh;
    if (state == O_MAC || state == O_DRN) begin
      a_op = hid_op;
      b_op = q_wo;
    end
  end

  assign prod     = a_op * b_op;
  assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
  assign acc_next = mac_vld ? acc + prod_ext : acc;
  assign shifted  = acc_next >>> (DW-1);

  always_comb begin
    clamped = shifted[10:0];
    if (shifted > S_MAX) begin
      clamped = 11'sd1023;
    end else if (shifted < S_MIN) begin
      clamped = -11'sd1024;
    end
  end

  // Adding 1024 to an 11-bit two's complement value just flips its sign bit.
  assign act_next = {~clamped[10], clamped[9:0]};

`ifdef SNN_TIE_LAST_EN
  assign take = (act_q >= best_val);
`else
  assign take = (act_q > best_val);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_HID; i++) begin
        hid[i] <= '0;
      end
      hid_op <= '0;
    end else begin
      hid_op <= hid[hid_idx];
      if (state == H_WB) begin
        hid[hid_idx] <= act_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      digit    <= '0;
      max_val  <= '0;
      in_idx   <= '0;
      hid_idx  <= '0;
      out_idx  <= '0;
      acc      <= '0;
      mac_vld  <= 1'b0;
      act_addr <= '0;
      best_val <= '0;
      best_idx <= '0;
    end else begin
      mac_vld <= (state == H_MAC) || (state == O_MAC);
      acc     <= acc_next;
      case (state)
        IDLE: begin
          done    <= 1'b0;
          in_idx  <= '0;
          hid_idx <= '0;
          out_idx <= '0;
          acc     <= '0;
          if (start) begin
            busy  <= 1'b1;
            state <= H_MAC;
          end
        end
        H_MAC: begin
          if (in_idx == IN_LAST) begin
            in_idx <= '0;
            state  <= H_DRN;
          end else begin
            in_idx <= in_idx + 1'b1;
          end
        end
        H_DRN: begin
          act_addr <= act_next;
          state    <= H_ACT;
        end
        H_ACT: state <= H_WB;
        H_WB: begin
          acc <= '0;
          if (hid_idx == HID_LAST) begin
            hid_idx <= '0;
            state   <= O_MAC;
          end else begin
            hid_idx <= hid_idx + 1'b1;
            state   <= H_MAC;
          end
        end
        O_MAC: begin
          if (hid_idx == HID_LAST) begin
            hid_idx <= '0;
            state   <= O_DRN;
          end else begin
            hid_idx <= hid_idx + 1'b1;
          end
        end
        O_DRN: begin
          act_addr <= act_next;
          state    <= O_ACT;
        end
        O_ACT: state <= O_WB;
        O_WB: begin
          acc <= '0;
          // Output 0 seeds the running max unconditionally.
          if (out_idx == '0 || take) begin
            best_val <= act_q;
            best_idx <= out_idx;
          end
          if (out_idx == OUT_LAST) begin
            state <= DONE;
          end else begin
            out_idx <= out_idx + 1'b1;
            state   <= O_MAC;
          end
        end
        DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          digit   <= best_idx;
          max_val <= best_val;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_core_param.sv
`timescale 1ns/1ps
// Scoreboard bench for snn_core_param: a reduced 16-4-10 core for function, a default-size core for latency.
module tb_snn_core_param;

  localparam int N_IN  = 16;
  localparam int N_HID = 4;
  localparam int N_OUT = 10;
  localparam int LAT_S = N_HID*(N_IN+3) + N_OUT*(N_HID+3) + 1;
  localparam int LAT_F = 25535;
`ifdef SNN_TIE_LAST_EN
  localparam logic [3:0] TIE_D  = 4'd9;
  localparam logic [3:0] TIE2_D = 4'd5;
`else
  localparam logic [3:0] TIE_D  = 4'd0;
  localparam logic [3:0] TIE2_D = 4'd2;
`endif

  logic        clk = 1'b0;
  logic        rst, start, start_f;
  logic        busy, done, q_in;
  logic [3:0]  digit;
  logic [7:0]  max_val, q_wh, q_wo, act_q;
  logic [3:0]  addr_in;
  logic [5:0]  addr_wh, addr_wo;
  logic [10:0] act_addr;

  logic        busy_f, done_f;
  logic        q_in_f = 1'b0;
  logic [7:0]  q_wh_f = 8'h00, q_wo_f = 8'h00, act_q_f;
  logic [3:0]  digit_f;
  logic [7:0]  max_val_f;
  logic [9:0]  addr_in_f;
  logic [14:0] addr_wh_f;
  logic [8:0]  addr_wo_f;
  logic [10:0] act_addr_f;

  logic        pix [N_IN];
  logic [7:0]  wh  [N_IN*N_HID];
  logic [7:0]  wo  [N_HID*N_OUT];
  logic [7:0]  lut [2048];

  logic [11:0] sb_q [$];
  logic [11:0] sb_f [$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  snn_core_param #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .DW(8), .ACC_W(26)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .digit(digit), .max_val(max_val),
    .addr_in(addr_in), .q_in(q_in), .addr_wh(addr_wh), .q_wh(q_wh),
    .addr_wo(addr_wo), .q_wo(q_wo), .act_addr(act_addr), .act_q(act_q)
  );

  snn_core_param dut_full (
    .clk(clk), .rst(rst), .start(start_f), .busy(busy_f), .done(done_f),
    .digit(digit_f), .max_val(max_val_f),
    .addr_in(addr_in_f), .q_in(q_in_f), .addr_wh(addr_wh_f), .q_wh(q_wh_f),
    .addr_wo(addr_wo_f), .q_wo(q_wo_f), .act_addr(act_addr_f), .act_q(act_q_f)
  );

  // Synchronous ROM/LUT models with one cycle of read latency.
  always @(posedge clk) begin
    q_in    <= pix[addr_in];
    q_wh    <= wh[addr_wh];
    q_wo    <= wo[addr_wo];
    act_q   <= lut[act_addr];
    act_q_f <= lut[act_addr_f];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse consumes one expected {digit, max_val}.
  always @(negedge clk) begin
    logic [11:0] e;
    if (done) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, required no pending result");
      end else begin
        e = sb_q.pop_front();
        check("digit", {28'd0, digit}, {28'd0, e[11:8]});
        check("max_val", {24'd0, max_val}, {24'd0, e[7:0]});
      end
    end
    if (done_f) begin
      if (sb_f.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done_full: got done=1, required no pending result");
      end else begin
        e = sb_f.pop_front();
        check("digit_full", {28'd0, digit_f}, {28'd0, e[11:8]});
        check("max_val_full", {24'd0, max_val_f}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < N_IN; i++) pix[i] = 1'b0;
    for (int i = 0; i < N_IN*N_HID; i++) wh[i] = 8'h00;
    for (int i = 0; i < N_HID*N_OUT; i++) wo[i] = 8'h00;
  endtask

  task automatic load_single_path();
    clear_mem();
    pix[5] = 1'b1;
    wh[3*N_IN + 5] = 8'h40;
    wo[7*N_HID + 3] = 8'h40;
  endtask

  // One start pulse; checks latency, busy, optional hidden act_addr and a mid-run start pulse.
  task automatic run(input string tag, input logic [11:0] exp_res, input int sat_exp, input int pulse_at);
    int n;
    int busy_bad;
    sb_q.push_back(exp_res);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    busy_bad = 0;
    while (!done && n < LAT_S + 50) begin
      if (busy !== 1'b1) busy_bad++;
      if (sat_exp >= 0) begin
        for (int h = 0; h < N_HID; h++) begin
          if (n == h*(N_IN+3) + N_IN + 1) check("hid_act_addr", {21'd0, act_addr}, sat_exp);
        end
      end
      if (n == pulse_at) start = 1'b1;
      if (n == pulse_at + 3) start = 1'b0;
      @(negedge clk);
      n++;
    end
    $display("[TB] run %s: done after %0d cycles digit=%0d max_val=%0h", tag, n, digit, max_val);
    check("latency", n, LAT_S);
    check("busy_during_run", busy_bad, 0);
    check("busy_at_done", {31'd0, busy}, 0);
  endtask

  initial begin
    int nd, d1, d2, n;
    for (int i = 0; i < 2048; i++) lut[i] = i[10:3];
    rst = 1'b1;
    start = 1'b0;
    start_f = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_digit", {28'd0, digit}, 0);
    check("rst_max_val", {24'd0, max_val}, 0);
    check("rst_addr_in", {28'd0, addr_in}, 0);
    check("rst_addr_wh", {26'd0, addr_wh}, 0);
    check("rst_addr_wo", {26'd0, addr_wo}, 0);
    check("rst_act_addr", {21'd0, act_addr}, 0);
    rst = 1'b0;

    // Zero weights: every unit sees act_addr 1024, LUT[1024]=0x80, all outputs tie.
    for (int i = 0; i < N_IN; i++) pix[i] = i[0];
    run("zero_weights", {TIE_D, 8'h80}, -1, 40);

    // hid3: 127*64=8128 -> s=63 -> LUT[1087]=0x87; out7: 64*-121=-7744 -> s=-61 -> LUT[963]=0x78.
    load_single_path();
    run("single_path", {4'd7, 8'h78}, -1, -1);

    // All hidden = LUT[1024] = -128; outputs 2 and 5 get -128 -> s=-1 -> LUT[1023]=0x7F.
    clear_mem();
    wo[2*N_HID + 1] = 8'h01;
    wo[5*N_HID + 1] = 8'h01;
    run("tie_pair", {TIE2_D, 8'h7F}, -1, -1);

    // Abort mid-run: outputs clear, no done follows.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_digit", {28'd0, digit}, 0);
    check("abort_max_val", {24'd0, max_val}, 0);
    check("abort_act_addr", {21'd0, act_addr}, 0);
    rst = 1'b0;
    repeat (LAT_S + 10) @(negedge clk);
    start = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    check("start_rst_busy", {31'd0, busy}, 0);
    repeat (20) @(negedge clk);
    $display("[TB] reset abort and start+rst sequence complete");

    load_single_path();
    run("after_abort", {4'd7, 8'h78}, -1, -1);

    // start held high across a whole run: back-to-back runs, one done each.
    sb_q.push_back({4'd7, 8'h78});
    sb_q.push_back({4'd7, 8'h78});
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    nd = 0; d1 = -1; d2 = -1;
    for (int k = 0; k < 2*LAT_S + 20; k++) begin
      if (done) begin
        if (nd == 0) d1 = k;
        else if (nd == 1) d2 = k;
        nd++;
      end
      if (k == LAT_S + 5) start = 1'b0;
      @(negedge clk);
    end
    $display("[TB] held start: %0d dones at cycles %0d and %0d", nd, d1, d2);
    check("held_done_count", nd, 2);
    check("held_first_done", d1, LAT_S);
    check("held_second_done", d2, 2*LAT_S + 1);

    // Saturation both ways; hidden act = LUT[2047] or LUT[0], outputs stay at 1024.
    clear_mem();
    for (int i = 0; i < N_IN; i++) pix[i] = 1'b1;
    for (int i = 0; i < N_IN*N_HID; i++) wh[i] = 8'h7F;
    run("sat_pos", {TIE_D, 8'h80}, 2047, -1);
    for (int i = 0; i < N_IN*N_HID; i++) wh[i] = 8'h80;
    run("sat_neg", {TIE_D, 8'h80}, 0, -1);

    // Default-size core with zero weights: exact latency.
    sb_f.push_back({TIE_D, 8'h80});
    @(negedge clk) start_f = 1'b1;
    @(negedge clk) start_f = 1'b0;
    n = 0;
    while (!done_f && n < LAT_F + 100) begin
      @(negedge clk);
      n++;
    end
    $display("[TB] run full_size: done after %0d cycles digit=%0d max_val=%0h", n, digit_f, max_val_f);
    check("latency_full", n, LAT_F);
    check("busy_full_at_done", {31'd0, busy_f}, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size() + sb_f.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
